// File: rtl/imagem_stream_pkg.sv
// rtl/imagem_stream_pkg.sv - shared types and constants for the image pixel streamer
package imagem_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_PIX_W      = 8;
  localparam int BYTES_PER_WORD = DEF_DATA_W / DEF_PIX_W;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imagem_prefetch_fifo.sv
// rtl/imagem_prefetch_fifo.sv - synchronous prefetch FIFO with count/full/empty
module imagem_prefetch_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              push_i,
  input  logic [DATA_W-1:0]                 push_data_i,
  input  logic                              pop_i,
  output logic [DATA_W-1:0]                 head_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              full_o,
  output logic                              empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/imagem_pixel_streamer.sv
// rtl/imagem_pixel_streamer.sv - fetches a word range from image RAM and streams it as pixels
module imagem_pixel_streamer
  import imagem_stream_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int PIX_W        = DEF_PIX_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_e                  state_q;
  logic [ADDR_W-1:0]       base_q, issued_q;
  logic [ADDR_W:0]         words_left_q, pop_left_q;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [BYTE_IDX_W-1:0]   byte_q;
  logic [DATA_W-1:0]       head;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full, fifo_empty;
  logic                    issue, push, accept, pop;
  int                      inflight;

  // Credit: words already buffered plus reads still returning must fit in the FIFO.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + int'(pipe_q[i]);
    issue  = (state_q == RUN) && (words_left_q != '0) &&
             (int'(fifo_count) + inflight < FIFO_DEPTH);
    pipe_d    = pipe_q << 1;
    pipe_d[0] = issue;
  end

  assign push      = pipe_q[READ_LATENCY-1];
  assign pix_valid = !fifo_empty;
  assign accept    = pix_valid && pix_ready;
  assign pop       = accept && (byte_q == LAST_BYTE);
  assign pix_data  = pix_valid ? head[byte_q*PIX_W +: PIX_W] : '0;
  assign pix_last  = pix_valid && (byte_q == LAST_BYTE) && (pop_left_q == (ADDR_W+1)'(1));

  assign mem_chipselect = issue;
  assign mem_address    = base_q + issued_q;
  assign mem_clken      = 1'b1;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

  imagem_prefetch_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (mem_readdata),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset_n) assert (!(push && fifo_full && !pop));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      issued_q     <= '0;
      words_left_q <= '0;
      pop_left_q   <= '0;
      pipe_q       <= '0;
      byte_q       <= '0;
    end else begin
      pipe_q <= pipe_d;
      if (accept) byte_q <= pop ? '0 : byte_q + 1'b1;
      if (pop) pop_left_q <= pop_left_q - 1'b1;
      case (state_q)
        IDLE: if (start) begin
          base_q       <= base_addr;
          issued_q     <= '0;
          words_left_q <= word_count;
          pop_left_q   <= word_count;
          state_q      <= (word_count != '0) ? RUN : DONE;
        end
        RUN: if (issue) begin
          issued_q     <= issued_q + 1'b1;
          words_left_q <= words_left_q - 1'b1;
          if (words_left_q == (ADDR_W+1)'(1)) state_q <= DRAIN;
        end
        DRAIN: if (fifo_empty && inflight == 0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imagem_pixel_streamer.sv
// tb/tb_imagem_pixel_streamer.sv - scoreboard bench for imagem_pixel_streamer
module tb_imagem_pixel_streamer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] word_count = '0;
  logic        busy, done, mem_chipselect, mem_clken, pix_valid, pix_last;
  logic        pix_ready = 1'b0;
  logic [13:0] mem_address;
  logic [31:0] mem_readdata;
  logic [7:0]  pix_data;

  logic [31:0] ram [16384];
  logic [13:0] ram_addr_q = '0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int px_acc = 0;
  int issues = 0;
  int pops = 0;
  int bpos = 0;
  int ready_mode = 0;
  logic       prev_stall = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] held_data = '0;
  logic       held_last = 1'b0;

  logic [8:0]  exp_q [$];
  logic [13:0] addr_q [$];

  imagem_pixel_streamer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_last       (pix_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_chipselect && mem_clken) ram_addr_q <= mem_address;
  assign mem_readdata = ram[ram_addr_q];

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = ($urandom_range(0, 9) >= 3);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_bytes(input logic [31:0] w, input logic last_word);
    for (int b = 0; b < 4; b++) exp_q.push_back({last_word && b == 3, w[b*8 +: 8]});
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      bpos = 0;
      issues = 0;
      pops = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", pix_valid, 1);
        chk("hold_data", pix_data, held_data);
        chk("hold_last", pix_last, held_last);
      end
      if (prev_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
      end
      if (done) done_cnt++;
      if (mem_chipselect) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read actual=%h required=none", mem_address);
        end else chk("mem_address", mem_address, addr_q.pop_front());
        issues++;
      end
      chk("outstanding_le4", (issues - pops) <= 4, 1);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel actual=%h required=none", pix_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("pix_data", pix_data, e[7:0]);
          chk("pix_last", pix_last, e[8]);
        end
        px_acc++;
        if (bpos == 3) pops++;
        bpos = (bpos + 1) % 4;
      end
      prev_stall = pix_valid && !pix_ready;
      held_data  = pix_data;
      held_last  = pix_last;
      prev_done  = done;
    end
  end

  task automatic do_start(input logic [13:0] base, input logic [14:0] cnt);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_words(input logic [13:0] base, input int cnt);
    logic [13:0] a;
    for (int k = 0; k < cnt; k++) begin
      a = base + 14'(k);
      addr_q.push_back(a);
      push_bytes(ram[a], k == cnt - 1);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      if (done_cnt > d0) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_count"}, done_cnt - d0, 1);
    chk({name, "_pixels_left"}, exp_q.size(), 0);
    chk({name, "_reads_left"}, addr_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_cs"}, mem_chipselect, 0);
    chk({name, "_addr"}, mem_address, 0);
    chk({name, "_valid"}, pix_valid, 0);
    chk({name, "_last"}, pix_last, 0);
    chk({name, "_data"}, pix_data, 0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    ram[14'h10] = 32'h44332211;
    ram[14'h11] = 32'h88776655;
    for (int k = 0; k < 8; k++) ram[14'h40 + k] = {8'hD0 + 8'(k), 8'hC0 + 8'(k), 8'hB0 + 8'(k), 8'hA0 + 8'(k)};
    ram[14'h3FFF] = 32'hDDCCBBAA;
    ram[14'h0000] = 32'h04030201;
    for (int k = 0; k < 3; k++) ram[14'h50 + k] = 32'h50505050 + 32'(k);
    ram[14'h60] = 32'h66666666;
    ram[14'h61] = 32'h67676767;
    for (int k = 0; k < 4; k++) ram[14'h70 + k] = 32'h70717273 + 32'(k << 24);
    ram[14'h78] = 32'hCAFEF00D;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;

    // Basic: hand-computed bytes, last only on 0x88.
    ready_mode = 1;
    addr_q.push_back(14'h10);
    addr_q.push_back(14'h11);
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33}); exp_q.push_back({1'b0, 8'h44});
    exp_q.push_back({1'b0, 8'h55}); exp_q.push_back({1'b0, 8'h66});
    exp_q.push_back({1'b0, 8'h77}); exp_q.push_back({1'b1, 8'h88});
    do_start(14'h10, 15'd2);
    wait_done("basic", 100);

    // Backpressure with ~30% stalls.
    ready_mode = 2;
    expect_words(14'h40, 8);
    do_start(14'h40, 15'd8);
    wait_done("backpressure", 600);
    ready_mode = 1;

    // Zero count: no reads, no pixels, done in the cycle after the start cycle.
    do_start(14'h20, 15'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_done", done, (i == 0));
      chk("zero_cs", mem_chipselect, 0);
      chk("zero_valid", pix_valid, 0);
    end

    // Address wrap.
    addr_q.push_back(14'h3FFF);
    addr_q.push_back(14'h0000);
    exp_q.push_back({1'b0, 8'hAA}); exp_q.push_back({1'b0, 8'hBB});
    exp_q.push_back({1'b0, 8'hCC}); exp_q.push_back({1'b0, 8'hDD});
    exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b0, 8'h03}); exp_q.push_back({1'b1, 8'h04});
    do_start(14'h3FFF, 15'd2);
    wait_done("wrap", 100);

    // Second start while busy is ignored.
    expect_words(14'h50, 3);
    do_start(14'h50, 15'd3);
    @(posedge clk); #1;
    chk("busy_running", busy, 1);
    do_start(14'h60, 15'd2);
    wait_done("start_busy", 100);

    // Reset after three pixels of a four-word transfer.
    px_acc = 0;
    expect_words(14'h70, 4);
    do_start(14'h70, 15'd4);
    begin
      bit got;
      got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
        if (px_acc >= 3) got = 1;
        else begin @(posedge clk); #1; end
      end
      chk("reset_wait_3px", px_acc, 3);
    end
    reset_n = 1'b0;
    ready_mode = 0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("midreset");
    reset_n = 1'b1;
    ready_mode = 1;
    addr_q.push_back(14'h78);
    exp_q.push_back({1'b0, 8'h0D}); exp_q.push_back({1'b0, 8'hF0});
    exp_q.push_back({1'b0, 8'hFE}); exp_q.push_back({1'b1, 8'hCA});
    px_acc = 0;
    do_start(14'h78, 15'd1);
    wait_done("after_reset", 100);
    chk("after_reset_pixels", px_acc, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
